// File: rtl/fulladder_bist_if.sv
// Bus between the full-adder BIST controller and its surroundings: start/status
// toward the system controller, stimulus/response toward the adder under test.
interface fulladder_bist_if #(
    parameter int WIDTH = 1
) ();
    logic               start;
    logic [WIDTH-1:0]   tst_a;
    logic [WIDTH-1:0]   tst_b;
    logic               tst_cin;
    logic [WIDTH-1:0]   dut_s;
    logic               dut_cout;
    logic               busy;
    logic               done;
    logic               pass;
    logic [15:0]        err_count;
    logic [2*WIDTH:0]   fail_vec;

    modport slave (
        input  start, dut_s, dut_cout,
        output tst_a, tst_b, tst_cin, busy, done, pass, err_count, fail_vec
    );

    modport master (
        output start, dut_s, dut_cout,
        input  tst_a, tst_b, tst_cin, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/fulladder_bist.sv
// Built-in self-test controller: walks every {a,b,cin} vector into an adder under
// test, holds it SETTLE cycles, then compares the response against a golden sum.
module fulladder_bist #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1     // legal range 1..255
) (
    input  logic            clk,
    input  logic            rst_n,
    fulladder_bist_if.slave bus
);
    localparam int          VW          = 2 * WIDTH + 1;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [15:0] ERR_MAX     = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VW-1:0]      r_vec;
    logic [7:0]         r_settle;
    logic [15:0]        r_err_count;
    logic [VW-1:0]      r_fail_vec;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [WIDTH-1:0]   r_tst_a;
    logic [WIDTH-1:0]   r_tst_b;
    logic               r_tst_cin;

    logic               w_launch;
    logic               w_advance;
    logic               w_finish;
    logic               w_last;
    logic               w_mismatch;
    logic [VW-1:0]      w_vec_nxt;
    logic [WIDTH:0]     w_golden;

    function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    assign w_last     = &r_vec;
    assign w_vec_nxt  = r_vec + {{(VW-1){1'b0}}, 1'b1};
    // The stimulus registers equal V throughout DRIVE/CHECK, so they feed the golden model.
    assign w_golden   = golden_sum(r_tst_a, r_tst_b, r_tst_cin);
    assign w_mismatch = ({bus.dut_cout, bus.dut_s} != w_golden);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_DRIVE;
                    w_launch    = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_DRIVE: begin
                if (r_settle == SETTLE_LAST) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_CHECK: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_finish    = 1'b1;
                end else begin
                    w_state_nxt = ST_DRIVE;
                    w_advance   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Vector counter, settle counter and stimulus registers; stimulus moves only on DRIVE entry or DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec     <= {VW{1'b0}};
            r_settle  <= 8'd0;
            r_tst_a   <= {WIDTH{1'b0}};
            r_tst_b   <= {WIDTH{1'b0}};
            r_tst_cin <= 1'b0;
        end else begin
            if (r_state == ST_DRIVE && r_settle != SETTLE_LAST) begin
                r_settle <= r_settle + 8'd1;
            end else begin
                r_settle <= 8'd0;
            end
            if (w_launch || w_finish) begin
                r_vec     <= {VW{1'b0}};
                r_tst_a   <= {WIDTH{1'b0}};
                r_tst_b   <= {WIDTH{1'b0}};
                r_tst_cin <= 1'b0;
            end else if (w_advance) begin
                r_vec     <= w_vec_nxt;
                r_tst_a   <= w_vec_nxt[2*WIDTH:WIDTH+1];
                r_tst_b   <= w_vec_nxt[WIDTH:1];
                r_tst_cin <= w_vec_nxt[0];
            end
        end
    end

    // Result registers; a zero error count marks the first mismatch of the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 16'd0;
            r_fail_vec  <= {VW{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else if (w_launch) begin
            r_err_count <= 16'd0;
            r_fail_vec  <= {VW{1'b0}};
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            if (w_mismatch) begin
                if (r_err_count == 16'd0) begin
                    r_fail_vec <= r_vec;
                end
                if (r_err_count != ERR_MAX) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
            if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (r_err_count == 16'd0) && !w_mismatch;
            end
        end
    end

    assign bus.tst_a     = r_tst_a;
    assign bus.tst_b     = r_tst_b;
    assign bus.tst_cin   = r_tst_cin;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.fail_vec  = r_fail_vec;
endmodule

// File: tb/tb_fulladder_bist.sv
// Self-checking bench for fulladder_bist: a 1-bit instance with injectable adder
// faults and a 4-bit instance driving a ripple adder, checked through scoreboards.
module tb_fulladder_bist;
    logic clk;
    logic rst_n;
    int   fault_mode;
    int   checks;
    int   errors;
    int   busy_cnt1;
    int   busy_cnt4;
    bit   spot_seen;

    typedef struct packed {
        logic [15:0] err;
        logic [8:0]  fv;
        logic        pass;
    } res_t;

    logic [8:0] vq1[$];
    logic [8:0] vq4[$];
    res_t       rq1[$];
    res_t       rq4[$];

    fulladder_bist_if #(.WIDTH(1)) if1 ();
    fulladder_bist_if #(.WIDTH(4)) if4 ();

    fulladder_bist #(.WIDTH(1), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    fulladder_bist #(.WIDTH(4), .SETTLE(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-bit adder under test with optional faults
    wire fa_s = if1.tst_a ^ if1.tst_b ^ if1.tst_cin;
    wire fa_c = (if1.tst_a & if1.tst_b) | (if1.tst_cin & (if1.tst_a ^ if1.tst_b));
    assign if1.dut_s    = (fault_mode == 1) ? 1'b0 : fa_s;
    assign if1.dut_cout = (fault_mode == 2) ? ~fa_c : fa_c;

    // 4-bit ripple adder built from full adders
    wire [3:0] rs;
    wire [4:0] rc;
    assign rc[0] = if4.tst_cin;
    for (genvar i = 0; i < 4; i++) begin : g_rca
        assign rs[i]   = if4.tst_a[i] ^ if4.tst_b[i] ^ rc[i];
        assign rc[i+1] = (if4.tst_a[i] & if4.tst_b[i]) | (rc[i] & (if4.tst_a[i] ^ if4.tst_b[i]));
    end
    assign if4.dut_s    = rs;
    assign if4.dut_cout = rc[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stimulus per busy cycle and expected final result for the 1-bit instance
    task automatic push1(input int mode);
        res_t r;
        r = '0;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            logic a, b, ci, s, co, fs, fc;
            vv = 3'(v);
            a = vv[2]; b = vv[1]; ci = vv[0];
            s  = a ^ b ^ ci;
            co = (a & b) | (a & ci) | (b & ci);
            fs = (mode == 1) ? 1'b0 : s;
            fc = (mode == 2) ? ~co : co;
            if ({fc, fs} != {co, s}) begin
                if (r.err == 16'd0) r.fv = 9'(vv);
                r.err = r.err + 16'd1;
            end
            vq1.push_back(9'(vv));
            vq1.push_back(9'(vv));
        end
        r.pass = (r.err == 16'd0);
        rq1.push_back(r);
    endtask

    task automatic push4();
        res_t r;
        for (int v = 0; v < 512; v++) begin
            for (int k = 0; k < 3; k++) vq4.push_back(9'(v));
        end
        r.err = 16'd0; r.fv = 9'd0; r.pass = 1'b1;
        rq4.push_back(r);
    endtask

    task automatic pulse_start(input int sel);
        @(posedge clk); #1;
        if (sel == 1) if1.start = 1'b1;
        else          if4.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        if4.start = 1'b0;
    endtask

    task automatic wait_vec1(input logic [2:0] v, input int budget);
        int n = 0;
        while ({if1.tst_a, if1.tst_b, if1.tst_cin} != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_vec1_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_done(input int sel, input int exp_busy, input int budget);
        int   n = 0;
        logic prev_busy = 1'b0;
        logic d, b;
        res_t r;
        d = (sel == 1) ? if1.done : if4.done;
        b = (sel == 1) ? if1.busy : if4.busy;
        while (!d && n < budget) begin
            prev_busy = b;
            @(negedge clk);
            n++;
            d = (sel == 1) ? if1.done : if4.done;
            b = (sel == 1) ? if1.busy : if4.busy;
        end
        check("done_timeout", 32'(n < budget), 32'd1);
        check("busy_fall_with_done", 32'({prev_busy, b}), 32'd2);
        if (sel == 1) begin
            r = (rq1.size() > 0) ? rq1.pop_front() : '1;
            check("err_count1", 32'(if1.err_count), 32'(r.err));
            check("fail_vec1", 32'(if1.fail_vec), 32'(r.fv));
            check("pass1", 32'(if1.pass), 32'(r.pass));
            check("busy_cycles1", 32'(busy_cnt1), 32'(exp_busy));
            check("vq1_drained", 32'(vq1.size()), 32'd0);
        end else begin
            r = (rq4.size() > 0) ? rq4.pop_front() : '1;
            check("err_count4", 32'(if4.err_count), 32'(r.err));
            check("fail_vec4", 32'(if4.fail_vec), 32'(r.fv));
            check("pass4", 32'(if4.pass), 32'(r.pass));
            check("busy_cycles4", 32'(busy_cnt4), 32'(exp_busy));
            check("vq4_drained", 32'(vq4.size()), 32'd0);
        end
    endtask

    // Scoreboard monitor for the 1-bit instance
    always @(negedge clk) begin
        check("pass_without_done1", 32'(if1.pass & ~if1.done), 32'd0);
        if (rst_n && if1.busy) begin
            busy_cnt1++;
            if (vq1.size() == 0) check("vq1_underflow", 32'd1, 32'd0);
            else check("tst_vec1", 32'({if1.tst_a, if1.tst_b, if1.tst_cin}), 32'(vq1.pop_front()));
        end
    end

    // Scoreboard monitor for the 4-bit instance
    always @(negedge clk) begin
        check("pass_without_done4", 32'(if4.pass & ~if4.done), 32'd0);
        if (rst_n && if4.busy) begin
            busy_cnt4++;
            if (vq4.size() == 0) check("vq4_underflow", 32'd1, 32'd0);
            else check("tst_vec4", 32'({if4.tst_a, if4.tst_b, if4.tst_cin}), 32'(vq4.pop_front()));
            if ({if4.tst_a, if4.tst_b, if4.tst_cin} == 9'h1FF) begin
                spot_seen = 1'b1;
                check("spot_fff", 32'({if4.dut_cout, if4.dut_s}), 32'h1F);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; busy_cnt1 = 0; busy_cnt4 = 0; spot_seen = 1'b0;
        fault_mode = 0;
        rst_n = 1'b0;
        if1.start = 1'b0;
        if4.start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_status1", 32'({if1.busy, if1.done, if1.pass}), 32'd0);
        check("reset_results1", 32'({if1.err_count, if1.fail_vec}), 32'd0);
        check("reset_tst1", 32'({if1.tst_a, if1.tst_b, if1.tst_cin}), 32'd0);
        check("reset_all4", 32'({if4.busy, if4.done, if4.pass, if4.fail_vec, if4.tst_a, if4.tst_b, if4.tst_cin}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", 32'({if1.busy, if1.done}), 32'd0);

        // Correct 1-bit adder
        push1(0); busy_cnt1 = 0;
        pulse_start(1);
        wait_done(1, 16, 100);
        repeat (2) @(negedge clk);
        check("done_hold", 32'({if1.done, if1.busy}), 32'd2);
        check("done_tst_zero", 32'({if1.tst_a, if1.tst_b, if1.tst_cin}), 32'd0);

        // Sum stuck at 0
        fault_mode = 1;
        push1(1); busy_cnt1 = 0;
        pulse_start(1);
        wait_done(1, 16, 100);

        // Carry-out inverted
        fault_mode = 2;
        push1(2); busy_cnt1 = 0;
        pulse_start(1);
        wait_done(1, 16, 100);

        // 4-bit ripple adder, SETTLE=2
        push4(); busy_cnt4 = 0;
        pulse_start(4);
        wait_done(4, 1536, 2000);
        check("spot_seen", 32'(spot_seen), 32'd1);

        // Start mid-run is ignored; start in DONE restarts with cleared results
        fault_mode = 1;
        push1(1); busy_cnt1 = 0;
        pulse_start(1);
        wait_vec1(3'd3, 40);
        pulse_start(1);
        wait_done(1, 16, 100);
        fault_mode = 0;
        push1(0); busy_cnt1 = 0;
        pulse_start(1);
        @(negedge clk);
        check("restart_done_low", 32'({if1.done, if1.busy}), 32'd1);
        check("restart_cleared", 32'({if1.err_count, if1.fail_vec}), 32'd0);
        wait_done(1, 16, 100);

        // Asynchronous reset mid-run at V=5
        push1(0); busy_cnt1 = 0;
        pulse_start(1);
        wait_vec1(3'd5, 40);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_status", 32'({if1.busy, if1.done, if1.pass}), 32'd0);
        check("async_rst_results", 32'({if1.err_count, if1.fail_vec}), 32'd0);
        check("async_rst_tst", 32'({if1.tst_a, if1.tst_b, if1.tst_cin}), 32'd0);
        vq1.delete();
        rq1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", 32'({if1.busy, if1.done}), 32'd0);
        push1(0); busy_cnt1 = 0;
        pulse_start(1);
        wait_done(1, 16, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
